// File: rtl/keypad_key_fifo.sv
// -----------------------------------------------------------------------------
// keypad_key_fifo
//
// Sits behind the hex keypad scanner. Repeat strobes caused by contact bounce
// are rejected with a lockout window. Each accepted key code is queued in a
// small first-word-fall-through FIFO that the host drains at its own pace.
// Keys accepted while the FIFO is full are dropped and flagged by a sticky
// overflow bit.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   LOCKOUT  consecutive key_valid-low cycles needed after an accepted key
//            before the next key is accepted (>= 1)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-low
//   key_valid  scanner valid strobe
//   key_code   scanner key code, sampled only when key_valid = 1
//   rd_en      pop request
//   clr_ovf    clears overflow
//   rd_data    head-of-FIFO code (combinational read), meaningful when !empty
//   empty      FIFO holds no entries
//   full       FIFO holds DEPTH entries
//   count      number of entries held
//   key_event  one-cycle pulse per accepted key (pushed or dropped)
//   overflow   sticky: an accepted key was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module keypad_key_fifo #(
  parameter int DEPTH   = 8,
  parameter int LOCKOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [3:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     key_event,
  output logic                     overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LKW = $clog2(LOCKOUT) + 1;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [LKW-1:0]   lk, lk_nxt, lk_inc;
  logic             key_vld_p0;

  logic [3:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push, do_drop;

  // ---------------------------------------------------------------------------
  // Capture stage: lockout FSM decides whether this cycle's strobe is a key
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_ARMED;
      lk    <= '0;
    end else begin
      state <= state_nxt;
      lk    <= lk_nxt;
    end
  end

  assign lk_inc = lk + LKW'(1);

  always_comb begin
    state_nxt  = state;
    lk_nxt     = lk;
    key_vld_p0 = 1'b0;
    unique case (state)
      ST_ARMED: begin
        if (key_valid) begin
          key_vld_p0 = 1'b1;
          lk_nxt     = '0;
          state_nxt  = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (key_valid) begin
          // Bounce inside the window restarts it.
          lk_nxt = '0;
        end else begin
          lk_nxt = lk_inc;
          if (lk_inc == LKW'(LOCKOUT)) begin
            state_nxt = ST_ARMED;
          end
        end
      end
      default: begin
        state_nxt = ST_ARMED;
        lk_nxt    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue stage: FWFT FIFO with extra wrap bit on each pointer
  // ---------------------------------------------------------------------------
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop on an empty FIFO is ignored, so a push+pop on empty only pushes.
  assign do_pop  = rd_en && !empty;
  // When full, a same-cycle pop frees the slot before the push lands.
  assign do_push = key_vld_p0 && (!full || rd_en);
  assign do_drop = key_vld_p0 && full && !rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= key_code;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Status stage: event pulse and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_event <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      key_event <= key_vld_p0;
      // A drop in the same cycle as a clear leaves the flag set.
      if (do_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_key_fifo.sv
module tb_keypad_key_fifo;

  localparam int DEPTH   = 8;
  localparam int LOCKOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        key_event;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] q[$];
  bit         m_ovf = 0;
  bit         m_ev  = 0;
  bit         seen  = 0;   // a key has been accepted since reset
  int         cyc   = 0;
  int         last_hi = 0; // edge index of most recent key_valid high

  keypad_key_fifo #(.DEPTH(DEPTH), .LOCKOUT(LOCKOUT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .key_event(key_event), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One clock edge with the given inputs; the model applies the rules at the
  // same edge. A key is accepted when no key has been accepted since reset,
  // or when more than LOCKOUT edges have passed since the last strobe.
  task automatic cycle(input logic kv, input logic [3:0] code,
                       input logic rd, input logic clr);
    bit acc, fullb, drop;
    key_valid = kv; key_code = code; rd_en = rd; clr_ovf = clr;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      q.delete(); m_ovf = 0; m_ev = 0; seen = 0;
    end else begin
      acc = kv && (!seen || (cyc - last_hi) > LOCKOUT);
      if (kv) last_hi = cyc;
      if (acc) seen = 1;
      fullb = (q.size() == DEPTH);
      if (rd && q.size() > 0) void'(q.pop_front());
      drop = acc && fullb && !rd;
      if (acc && !drop) q.push_back(code);
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_ev = acc;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++;
    if (key_event !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ev=%b ovf=%b want 0 0", key_event, overflow);
    end
  endtask

  task automatic test_single;
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    n_checks++;
    if (key_event !== 1'b1) begin n_fail++; $display("FAIL single_event: got %b want 1", key_event); end
    n_checks++;
    if (empty !== 1'b0 || count !== 4'd1) begin
      n_fail++; $display("FAIL single_count: got empty=%b count=%0d want 0 1", empty, count);
    end
    n_checks++;
    if (rd_data !== 4'hA) begin n_fail++; $display("FAIL single_data: got %h want a", rd_data); end
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    n_checks++;
    if (key_event !== 1'b0) begin n_fail++; $display("FAIL single_pulse_end: got %b want 0", key_event); end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    n_checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL single_pop: got empty=%b count=%0d want 1 0", empty, count);
    end
    idle(LOCKOUT + 2);
  endtask

  task automatic test_bounce;
    int ev_n = 0;
    for (int t = 0; t < 26; t++) begin
      logic kv;
      logic [3:0] c;
      kv = (t == 0 || t == 3 || t == 9);
      c  = (t == 0) ? 4'h5 : (t == 3) ? 4'h6 : 4'h7;
      cycle(kv, c, 1'b0, 1'b0);
      if (key_event === 1'b1) ev_n++;
    end
    n_checks++;
    if (ev_n != 1) begin n_fail++; $display("FAIL bounce_events: got %0d want 1", ev_n); end
    n_checks++;
    if (count !== 4'd1 || rd_data !== 4'h5) begin
      n_fail++; $display("FAIL bounce_queue: got count=%0d head=%h want 1 5", count, rd_data);
    end
    cycle(1'b1, 4'h7, 1'b0, 1'b0);   // edge 9+17
    n_checks++;
    if (key_event !== 1'b1 || count !== 4'd2) begin
      n_fail++; $display("FAIL bounce_rearm: got ev=%b count=%0d want 1 2", key_event, count);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    n_checks++;
    if (rd_data !== 4'h7) begin n_fail++; $display("FAIL bounce_second: got %h want 7", rd_data); end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    idle(LOCKOUT + 2);
  endtask

  task automatic test_fill_overflow;
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 4'(k), 1'b0, 1'b0);
      idle(19);
    end
    n_checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1 8", full, count);
    end
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    n_checks++;
    if (key_event !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_overflow: got ev=%b ovf=%b want 1 1", key_event, overflow);
    end
    n_checks++;
    if (count !== 4'd8 || rd_data !== 4'h0) begin
      n_fail++; $display("FAIL fill_unchanged: got count=%0d head=%h want 8 0", count, rd_data);
    end
    idle(19);
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (rd_data !== 4'(k)) begin n_fail++; $display("FAIL fill_order: got %h want %h", rd_data, 4'(k)); end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
    end
    n_checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_drained: got empty=%b ovf=%b want 1 1", empty, overflow);
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_clr: got %b want 0", overflow); end
  endtask

  task automatic test_full_simul;
    logic [3:0] exp_seq [DEPTH];
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 4'(k), 1'b0, 1'b0);
      idle(19);
    end
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++; $display("FAIL fullsim_state: got count=%0d ovf=%b full=%b want 8 0 1", count, overflow, full);
    end
    for (int k = 0; k < DEPTH - 1; k++) exp_seq[k] = 4'(k + 1);
    exp_seq[DEPTH-1] = 4'hC;
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (rd_data !== exp_seq[k]) begin
        n_fail++; $display("FAIL fullsim_order: got %h want %h", rd_data, exp_seq[k]);
      end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
    end
    idle(LOCKOUT + 2);
  endtask

  task automatic test_empty_simul;
    cycle(1'b1, 4'h3, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd1 || rd_data !== 4'h3) begin
      n_fail++; $display("FAIL emptysim_push: got count=%0d head=%h want 1 3", count, rd_data);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL emptysim_pop: got count=%0d empty=%b ovf=%b want 0 1 0", count, empty, overflow);
    end
    idle(LOCKOUT + 2);
  endtask

  task automatic test_reset_mid_lockout;
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_clear: got count=%0d empty=%b want 0 1", count, empty);
    end
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd1 || rd_data !== 4'h2 || key_event !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_accept: got count=%0d head=%h ev=%b want 1 2 1", count, rd_data, key_event);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    idle(LOCKOUT + 2);
  endtask

  task automatic test_wrap;
    cycle(1'b1, 4'h0, 1'b0, 1'b0);
    idle(19);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    idle(19);
    for (int i = 2; i < 2 * DEPTH + 5; i++) begin
      n_checks++;
      if (rd_data !== 4'(i - 2)) begin
        n_fail++; $display("FAIL wrap_order: got %h want %h", rd_data, 4'(i - 2));
      end
      cycle(1'b1, 4'(i), 1'b1, 1'b0);
      n_checks++;
      if (count !== 4'd2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", count); end
      idle(19);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_drain: got empty=%b want 1", empty); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      logic kv, rd, clr;
      int rd_div;
      rd_div = (i < 1500) ? 40 : 4;
      kv  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, rd_div - 1) == 0);
      clr = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cycle(kv, 4'($urandom_range(0, 15)), rd, clr);
      n_checks++;
      if (int'(count) != q.size() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL rand_level @%0d: got count=%0d empty=%b full=%b want count=%0d", i, count, empty, full, q.size());
      end
      n_checks++;
      if (key_event !== m_ev || overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_flags @%0d: got ev=%b ovf=%b want %b %b", i, key_event, overflow, m_ev, m_ovf);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (rd_data !== q[0]) begin
          n_fail++; $display("FAIL rand_head @%0d: got %h want %h", i, rd_data, q[0]);
        end
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_fill_overflow();
    test_full_simul();
    test_empty_simul();
    test_reset_mid_lockout();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_key_fifo.md
# keypad_key_fifo

Downstream stage of the hex keypad scanner. It takes the scanner's `valid` strobe and 4-bit `code` and rejects repeat strobes caused by contact bounce with a lockout window. Each accepted key code is queued in a small first-word-fall-through FIFO. Host logic pops codes at its own pace; key presses that arrive while the FIFO is full are flagged by a sticky overflow bit.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `LOCKOUT`, 16: number of consecutive `key_valid`-low cycles required after an accepted key before the next key is accepted; minimum 1.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst`=0 at a rising edge resets).
- `key_valid` in 1: scanner valid strobe.
- `key_code` in 4: scanner key code, sampled only when `key_valid`=1.
- `rd_en` in 1: pop request.
- `clr_ovf` in 1: clears `overflow`.
- `rd_data` out 4: head-of-FIFO code; meaningful when `empty`=0.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out log2(`DEPTH`)+1: number of entries held.
- `key_event` out 1: one-cycle pulse per accepted key.
- `overflow` out 1: sticky; an accepted key was dropped because the FIFO was full.

## Operation
- Capture FSM, two states, plus a lockout counter `lk` of width log2(`LOCKOUT`)+1.
- **ARMED**:
  - `key_valid`=1 makes the key accepted: `key_code` is offered to the FIFO as a push, `lk`←0, and the FSM goes to LOCKOUT.
  - `key_valid`=0: stay in ARMED.
- **LOCKOUT**:
  - `key_valid`=1 restarts the window: `lk`←0, no push.
  - `key_valid`=0 increments `lk`. When the incremented value equals `LOCKOUT`, the FSM goes to ARMED.
  - A `key_valid` in the cycle after the return to ARMED is accepted.
- Push, accepted key:
  - FIFO not full: write `mem[wr_ptr]`, advance `wr_ptr`.
  - FIFO full and `rd_en`=0: drop the code, set `overflow`.
  - FIFO full and `rd_en`=1 in the same cycle: the pop happens first, then the push is accepted. `count` stays `DEPTH` and `overflow` is unchanged.
- Pop:
  - `rd_en`=1 and `empty`=0: advance `rd_ptr`.
  - `rd_en`=1 and `empty`=1: ignored, no state change.
- Push and pop in the same cycle on a non-empty FIFO: both occur and `count` is unchanged.
- On an empty FIFO, a simultaneous push and `rd_en` performs only the push. The new entry is not popped.
- Pointers wrap modulo `DEPTH`. `count` = `wr_ptr` − `rd_ptr` using one extra wrap bit. `full` = (`count`==`DEPTH`), `empty` = (`count`==0).
- `overflow` is cleared by `clr_ovf`=1 or by reset. If `clr_ovf` and a drop occur in the same cycle, the set wins.
- `key_event` pulses for every accepted key, whether it is pushed or dropped.

## Timing
- Reset values:
  - FSM ARMED, `lk`=0, pointers 0.
  - `empty`=1, `full`=0, `count`=0, `key_event`=0, `overflow`=0, `rd_data`=don't-care.
  - Memory contents are not reset.
- Reset while in LOCKOUT or with data queued discards everything. The first `key_valid` after `rst` returns high is accepted.
- Accepted `key_valid` sampled at edge N:
  - `key_event`=1 during cycle N..N+1 only.
  - `count` is incremented and `empty`=0 after edge N.
  - `rd_data` equals the code in the same cycle (FWFT, head read combinationally from `mem[rd_ptr]`).
- Pop at edge N: `rd_data` shows the next entry after edge N. Latency is 0 cycles from `rd_en` to the new head.
- Lockout:
  - The minimum spacing between accepted keys is `LOCKOUT`+1 cycles, for a single-cycle `key_valid`.
  - With `key_valid` held high for H cycles, the next key is accepted no earlier than H+`LOCKOUT` cycles after the first.
- No combinational path from `key_valid` to any output. Every output except `rd_data` is a register or derived from registers.

## Test plan
- Reset, then a single-cycle `key_valid` with `key_code`=4'hA → `key_event` pulses once; one cycle later `empty`=0, `count`=1, `rd_data`=A. Pulse `rd_en` → `empty`=1, `count`=0.
- Bounce: `key_valid` pulses at cycles 0, 3 and 9 with `LOCKOUT`=16 and codes 5, 6, 7 → only code 5 is queued and there is one `key_event`. `key_valid` at cycle 9+17 with code 7 → accepted.
- Fill: 8 keys 0..7 spaced 20 cycles apart → `full`=1, `count`=8. A ninth key with code F → `key_event`=1, `overflow`=1, FIFO contents unchanged. Pop 8 times → codes come out 0..7 in order. `clr_ovf` → `overflow`=0.
- Full plus simultaneous: FIFO full with head 0, then key C arrives together with `rd_en`=1 → `count` stays 8, `overflow`=0, the last entry popped is C.
- Empty plus simultaneous: key 3 arrives with `rd_en`=1 on an empty FIFO → `count`=1, `rd_data`=3. `rd_en` on an empty FIFO → no change, `count`=0.
- Reset mid-lockout: accept key 9, drive `rst`=0 for one edge, then `key_valid` with code 2 on the first cycle after release → `count`=1, `rd_data`=2. Also check that pointers wrap across more than 2×`DEPTH` push/pop pairs and order is preserved.
